// File: rtl/step_ctrl.sv
// Execution-enable controller: debounces the step button and turns each press
// into a burst of single-cycle cpu_en pulses, with a run switch for free-running.
module step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20,
  parameter int BURST_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_raw,
  input  logic               run_sw,
  input  logic [BURST_W-1:0] burst_len,
  output logic               cpu_en,
  output logic               busy,
  output logic               btn_level,
  output logic [31:0]        step_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]    DB_ZERO   = {DB_W{1'b0}};
  localparam logic [DB_W-1:0]    DB_ONE    = {{(DB_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] REM_ZERO  = {BURST_W{1'b0}};
  localparam logic [BURST_W-1:0] REM_ONE   = {{(BURST_W-1){1'b0}}, 1'b1};

  state_t             state;
  state_t             state_nxt;
  logic               s1;
  logic               s2;
  logic [DB_W-1:0]    cnt;
  logic               press;
  logic [BURST_W-1:0] rem;
  logic [BURST_W-1:0] rem_nxt;

  // Synchroniser and debounce; press fires together with an accepted 0->1 level.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      cnt       <= DB_ZERO;
      btn_level <= 1'b0;
      press     <= 1'b0;
    end else begin
      s1    <= btn_raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == btn_level) begin
        cnt <= DB_ZERO;
      end else if (cnt == DB_LAST) begin
        btn_level <= s2;
        cnt       <= DB_ZERO;
        press     <= s2;
      end else begin
        cnt <= cnt + DB_ONE;
      end
    end
  end

  // FSM state and remaining-steps register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= REM_ZERO;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Next-state logic; burst_len is captured only when a burst starts.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    case (state)
      IDLE: begin
        if (run_sw) begin
          state_nxt = RUN;
        end else if (press) begin
          state_nxt = BURST;
          rem_nxt   = (burst_len == REM_ZERO) ? REM_ONE : burst_len;
        end else begin
          state_nxt = IDLE;
        end
      end
      BURST: begin
        rem_nxt = rem - REM_ONE;
        if (rem == REM_ONE) begin
          state_nxt = run_sw ? RUN : IDLE;
        end else begin
          state_nxt = BURST;
        end
      end
      RUN: begin
        if (!run_sw) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
        rem_nxt   = REM_ZERO;
      end
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    cpu_en = (state == BURST) || (state == RUN);
    busy   = (state != IDLE);
  end

  // Executed-step counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= 32'd0;
    end else if (cpu_en) begin
      step_cnt <= step_cnt + 32'd1;
    end else begin
      step_cnt <= step_cnt;
    end
  end

endmodule
